// File: rtl/segment_char_decoder.sv
// rtl/segment_char_decoder.sv - seven-segment pattern to ASCII decoder with debounce and valid/ready output
//
// Purpose: samples seven active-low segment lines that are asynchronous to
// i_Clk, waits until the pattern has held for STABLE_CYCLES clocks, and reports
// each newly displayed pattern once as an ASCII character.
//
// Ports:
//   i_Clk                   clock, rising edge
//   i_Rst_L                 asynchronous active-low reset
//   i_segLED_A..i_segLED_G  segment lines, active-low, asynchronous
//   i_Ready                 consumer accepts o_Char when high with o_Valid
//   o_Char                  decoded ASCII character
//   o_Valid                 o_Char holds an unconsumed character
//   o_Unknown               pattern matched no table entry (qualified by o_Valid)
//   o_Overrun               one-cycle pulse: unconsumed character overwritten

module segment_char_decoder #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_segLED_A,
  input  logic       i_segLED_B,
  input  logic       i_segLED_C,
  input  logic       i_segLED_D,
  input  logic       i_segLED_E,
  input  logic       i_segLED_F,
  input  logic       i_segLED_G,
  input  logic       i_Ready,
  output logic [7:0] o_Char,
  output logic       o_Valid,
  output logic       o_Unknown,
  output logic       o_Overrun
);

  localparam logic [15:0] STABLE_MAX  = 16'(STABLE_CYCLES);
  localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  sync1_q, sync2_q;
  logic [15:0] cnt_q, cnt_d;
  logic [6:0]  last_p_q, last_p_d;
  logic [7:0]  char_q, char_d;
  logic        unknown_q, unknown_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  logic [6:0]  pat;
  logic        changed;
  logic        stable;
  logic        load;
  logic [8:0]  lut;

  // Returns {unknown, ascii}; pattern bits are {A,B,C,D,E,F,G}, active-high.
  function automatic logic [8:0] lookup(input logic [6:0] p);
    case (p)
      7'h7E:   lookup = {1'b0, 8'h30};
      7'h30:   lookup = {1'b0, 8'h31};
      7'h6D:   lookup = {1'b0, 8'h32};
      7'h79:   lookup = {1'b0, 8'h33};
      7'h33:   lookup = {1'b0, 8'h34};
      7'h5B:   lookup = {1'b0, 8'h35};
      7'h5F:   lookup = {1'b0, 8'h36};
      7'h70:   lookup = {1'b0, 8'h37};
      7'h7F:   lookup = {1'b0, 8'h38};
      7'h7B:   lookup = {1'b0, 8'h39};
      7'h77:   lookup = {1'b0, 8'h41};
      7'h1F:   lookup = {1'b0, 8'h62};
      7'h4E:   lookup = {1'b0, 8'h43};
      7'h3D:   lookup = {1'b0, 8'h64};
      7'h4F:   lookup = {1'b0, 8'h45};
      7'h47:   lookup = {1'b0, 8'h46};
      7'h00:   lookup = {1'b0, 8'h20};
      default: lookup = {1'b1, 8'h3F};
    endcase
  endfunction

  // Synchronizer resets to all-ones so an undriven display reads as blank.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_q <= 7'h7F;
      sync2_q <= 7'h7F;
    end else begin
      sync1_q <= {i_segLED_A, i_segLED_B, i_segLED_C, i_segLED_D,
                  i_segLED_E, i_segLED_F, i_segLED_G};
      sync2_q <= sync1_q;
    end
  end

  assign pat = ~sync2_q;
  // Change is detected between the two synchronizer stages, i.e. against the
  // value P takes next cycle; this saves a register stage and sets the
  // change-to-valid latency at 3+STABLE_CYCLES edges.
  assign changed = (sync1_q != sync2_q);
  assign stable  = !changed && (cnt_q == STABLE_LAST);
  assign load    = (state_q == DECODE);
  assign lut     = lookup(pat);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_p_d  = last_p_q;
    char_d    = char_q;
    unknown_d = unknown_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != STABLE_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      SETTLE: begin
        if (stable) begin
          state_d = (pat != last_p_q) ? DECODE : HOLD;
        end
      end
      DECODE: begin
        // A change arriving during the decode cycle must not be lost in HOLD.
        state_d = changed ? SETTLE : HOLD;
      end
      HOLD: begin
        if (changed) begin
          state_d = SETTLE;
        end
      end
      default: state_d = SETTLE;
    endcase

    if (valid_q && i_Ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      char_d    = lut[7:0];
      unknown_d = lut[8];
      last_p_d  = pat;
      valid_d   = 1'b1;
      overrun_d = valid_q && !i_Ready;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= SETTLE;
      cnt_q     <= '0;
      last_p_q  <= 7'h00;
      char_q    <= 8'h20;
      unknown_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_p_q  <= last_p_d;
      char_q    <= char_d;
      unknown_q <= unknown_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign o_Char    = char_q;
  assign o_Valid   = valid_q;
  assign o_Unknown = unknown_q;
  assign o_Overrun = overrun_q;

endmodule

// File: tb/tb_segment_char_decoder.sv
// tb/tb_segment_char_decoder.sv - self-checking bench for segment_char_decoder
module tb_segment_char_decoder;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
  logic       ready;
  logic [7:0] o_char;
  logic       o_valid, o_unknown, o_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] tbl_p [17] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F,
                             7'h70, 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D,
                             7'h4F, 7'h47, 7'h00};
  string tbl_c = "0123456789AbCdEF ";

  logic [8:0] obs_q [$];
  bit         mon_en = 1'b0;

  segment_char_decoder #(.STABLE_CYCLES(S)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_segLED_A (seg_a),
    .i_segLED_B (seg_b),
    .i_segLED_C (seg_c),
    .i_segLED_D (seg_d),
    .i_segLED_E (seg_e),
    .i_segLED_F (seg_f),
    .i_segLED_G (seg_g),
    .i_Ready    (ready),
    .o_Char     (o_char),
    .o_Valid    (o_valid),
    .o_Unknown  (o_unknown),
    .o_Overrun  (o_overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && o_valid && ready) obs_q.push_back({o_unknown, o_char});
  end

  // Expected {unknown, ascii} from the character table.
  function automatic logic [8:0] ref_decode(input logic [6:0] p);
    logic [8:0] r;
    r = {1'b1, 8'h3F};
    for (int i = 0; i < 17; i++) begin
      if (tbl_p[i] == p) r = {1'b0, 8'(tbl_c[i])};
    end
    return r;
  endfunction

  task automatic drive(input logic [6:0] p);
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = ~p;
  endtask

  task automatic wait_valid(input int limit, output int k);
    k = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(7'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (o_char !== 8'h20) begin n_fail++; $display("FAIL reset_char: got %h expected 20", o_char); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_unknown !== 1'b0) begin n_fail++; $display("FAIL reset_unknown: got %b expected 0", o_unknown); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", o_overrun); end
    rst_n = 1'b1;
  endtask

  task automatic test_blank_after_reset();
    int seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL blank_no_report: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_latency();
    int k;
    ready = 1'b0;
    @(negedge clk); drive(7'h79);
    wait_valid(30, k);
    n_checks++; if (k !== S + 3) begin n_fail++; $display("FAIL latency: got %0d edges expected %0d", k, S + 3); end
    n_checks++; if (o_char !== 8'h33) begin n_fail++; $display("FAIL char_3: got %h expected 33", o_char); end
    n_checks++; if (o_unknown !== 1'b0) begin n_fail++; $display("FAIL unknown_3: got %b expected 0", o_unknown); end
    ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL consume_3: got valid %b expected 0", o_valid); end
  endtask

  task automatic test_unknown();
    int k;
    ready = 1'b1;
    @(negedge clk); drive(7'h01);
    wait_valid(30, k);
    n_checks++; if (k !== S + 3) begin n_fail++; $display("FAIL unknown_latency: got %0d expected %0d", k, S + 3); end
    n_checks++; if (o_char !== 8'h3F) begin n_fail++; $display("FAIL unknown_char: got %h expected 3f", o_char); end
    n_checks++; if (o_unknown !== 1'b1) begin n_fail++; $display("FAIL unknown_flag: got %b expected 1", o_unknown); end
    @(posedge clk); #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL unknown_one_cycle: got valid %b expected 0", o_valid); end
  endtask

  task automatic test_overrun();
    int k;
    int ov = 0;
    ready = 1'b0;
    @(negedge clk); drive(7'h77);
    wait_valid(30, k);
    n_checks++; if (o_char !== 8'h41) begin n_fail++; $display("FAIL char_A: got %h expected 41", o_char); end
    @(negedge clk); drive(7'h1F);
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (o_overrun) ov++;
    end
    n_checks++; if (ov !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d expected 1", ov); end
    n_checks++; if (o_char !== 8'h62) begin n_fail++; $display("FAIL char_b: got %h expected 62", o_char); end
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_valid: got %b expected 1", o_valid); end
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic test_glitch();
    int k;
    int seen = 0;
    ready = 1'b1;
    @(negedge clk); drive(7'h70);
    wait_valid(30, k);
    n_checks++; if (o_char !== 8'h37) begin n_fail++; $display("FAIL char_7: got %h expected 37", o_char); end
    @(negedge clk); drive(7'h7F);
    repeat (2) @(negedge clk);
    drive(7'h70);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL glitch_no_report: got %0d valid cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int k;
    int ov = 0;
    ready = 1'b0;
    @(negedge clk); drive(7'h30);
    wait_valid(30, k);
    n_checks++; if (o_char !== 8'h31) begin n_fail++; $display("FAIL char_1: got %h expected 31", o_char); end
    @(negedge clk); drive(7'h6D);
    for (int i = 0; i < S + 2; i++) begin
      @(posedge clk); #1;
      if (o_overrun) ov++;
    end
    ready = 1'b1;
    @(posedge clk); #1;
    if (o_overrun) ov++;
    n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", o_valid); end
    n_checks++; if (o_char !== 8'h32) begin n_fail++; $display("FAIL b2b_char: got %h expected 32", o_char); end
    n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ov); end
    @(posedge clk); #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_consume: got valid %b expected 0", o_valid); end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    int seen = 0;
    ready = 1'b0;
    @(negedge clk); drive(7'h5B);
    wait_valid(30, k);
    n_checks++; if (o_char !== 8'h35) begin n_fail++; $display("FAIL char_5: got %h expected 35", o_char); end
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    drive(7'h00);
    #1;
    n_checks++; if (o_char !== 8'h20) begin n_fail++; $display("FAIL async_char: got %h expected 20", o_char); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_unknown !== 1'b0) begin n_fail++; $display("FAIL async_unknown: got %b expected 0", o_unknown); end
    n_checks++; if (o_overrun !== 1'b0) begin n_fail++; $display("FAIL async_overrun: got %b expected 0", o_overrun); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (o_valid || o_overrun) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL post_reset_quiet: got %0d active cycles expected 0", seen); end
  endtask

  task automatic test_random();
    logic [8:0] exp_q [$];
    logic [6:0] cur  = 7'h00;
    logic [6:0] last = 7'h00;
    logic [6:0] p;
    int d;
    int n = 30;
    ready = 1'b1;
    apply_reset();
    obs_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      do begin
        if ($urandom_range(0, 1) == 1) p = tbl_p[$urandom_range(0, 16)];
        else p = 7'($urandom_range(0, 127));
      end while (p == cur);
      if (i == n - 1) d = 20;
      else if ($urandom_range(0, 1) == 1) d = $urandom_range(1, S - 1);
      else d = $urandom_range(S + 3, S + 8);
      // A pattern is reported only if it outlasts the settle window and
      // differs from the most recently reported one.
      if (d >= S + 1 && p != last) begin
        exp_q.push_back(ref_decode(p));
        last = p;
      end
      cur = p;
      drive(p);
      repeat (d) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d reports expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_report[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ready = 1'b0;
    drive(7'h00);
    test_reset();
    test_blank_after_reset();
    test_latency();
    test_unknown();
    test_overrun();
    test_glitch();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
